// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU constants, opcodes and pipeline sizing helper.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    localparam int   ALU_W   = 32;
    localparam int   ALU_SEG = 8;

    // Number of segment stages; a degenerate SEG is clamped so elaboration
    // reaches the parameter check instead of dividing by zero.
    function automatic int seg_count(input int w, input int s);
        return (s < 1) ? 1 : w / s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_seg_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_seg_stage
//  Purpose  : One SEG-bit adder slice with carry in/out, valid/ready register
//             slice and pass-through of operands, partial sum and tag.
//  Revision : 1.0 - initial release
// ============================================================================
module add_seg_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int SEG   = ALU_SEG,
    parameter int IDX   = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic             c_in,
    input  logic             z_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out,
    output logic             z_out,
    output logic [TAG_W-1:0] tag_out
);

    logic [SEG:0]       seg_sum;
    logic               valid_d, valid_q;
    logic [WIDTH-1:0]   a_d, a_q, b_d, b_q, s_d, s_q;
    logic               c_d, c_q, z_d, z_q;
    logic [TAG_W-1:0]   tag_d, tag_q;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        seg_sum = {1'b0, a_in[IDX*SEG +: SEG]} + {1'b0, b_in[IDX*SEG +: SEG]}
                + {{SEG{1'b0}}, c_in};
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        z_d     = z_q;
        tag_d   = tag_q;
        if (in_ready) begin
            valid_d = in_valid;
        end
        // Payload only moves on a real transfer so stalled data stays put.
        if (in_valid && in_ready) begin
            a_d                  = a_in;
            b_d                  = b_in;
            s_d                  = s_in;
            s_d[IDX*SEG +: SEG]  = seg_sum[SEG-1:0];
            c_d                  = seg_sum[SEG];
            z_d                  = z_in && (seg_sum[SEG-1:0] == '0);
            tag_d                = tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            z_q     <= z_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign s_out     = s_q;
    assign c_out     = c_q;
    assign z_out     = z_q;
    assign tag_out   = tag_q;

endmodule
`default_nettype wire

// File: rtl/add_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_pipe
//  Purpose  : Segmented, pipelined add/subtract unit with valid/ready
//             handshake, carry/overflow/zero flags and a pass-through tag.
//  Revision : 1.0 - initial release
// ============================================================================
module add_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int SEG   = ALU_SEG,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);

    localparam int STAGES   = seg_count(WIDTH, SEG);
    localparam int MSB      = WIDTH - 1;
    localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;

    if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_params
        $error("add_pipe: WIDTH must be a positive integer multiple of SEG");
    end

    // Index k feeds stage k; index STAGES is the output of the last stage.
    logic             w_valid [STAGES+1];
    logic             w_ready [STAGES+1];
    logic [WIDTH-1:0] w_a     [STAGES+1];
    logic [WIDTH-1:0] w_b     [STAGES+1];
    logic [WIDTH-1:0] w_s     [STAGES+1];
    logic             w_c     [STAGES+1];
    logic             w_z     [STAGES+1];
    logic [TAG_W-1:0] w_tag   [STAGES+1];

    assign w_valid[0]      = in_valid;
    assign w_a[0]          = a;
    assign w_b[0]          = (sub == OP_SUB) ? ~b : b;
    assign w_s[0]          = '0;
    assign w_c[0]          = (sub == OP_SUB) ? 1'b1 : cin;
    assign w_z[0]          = 1'b1;
    assign w_tag[0]        = tag;
    assign in_ready        = w_ready[0];
    assign w_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_seg_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (w_valid[k]),
            .in_ready  (w_ready[k]),
            .a_in      (w_a[k]),
            .b_in      (w_b[k]),
            .s_in      (w_s[k]),
            .c_in      (w_c[k]),
            .z_in      (w_z[k]),
            .tag_in    (w_tag[k]),
            .out_valid (w_valid[k+1]),
            .out_ready (w_ready[k+1]),
            .a_out     (w_a[k+1]),
            .b_out     (w_b[k+1]),
            .s_out     (w_s[k+1]),
            .c_out     (w_c[k+1]),
            .z_out     (w_z[k+1]),
            .tag_out   (w_tag[k+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign sum       = w_s[STAGES];
    assign cout      = w_c[STAGES];
    assign zero      = w_z[STAGES];
    assign tag_out   = w_tag[STAGES];
    assign ovf       = (w_a[STAGES][MSB] == w_b[STAGES][MSB])
                    && (w_s[STAGES][MSB] != w_a[STAGES][MSB]);

    // Only the operand sign bits matter once the last segment is done.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{w_a[STAGES], w_b[STAGES]};

endmodule
`default_nettype wire
